// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Two-port round-robin arbiter in front of the SDRAM controller host port.
//   One command is in flight at a time. The grant is held until the
//   controller has finished the command, and read data is routed back to the
//   requester that owns the command.
//
//   Parameters
//     ADDR_WIDTH  host address width
//     DATA_WIDTH  host data width
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     mN_wr / mN_rd               requester N command requests (held to ack)
//     mN_addr / mN_wdata          requester N address and write data
//     mN_ack                      one-cycle pulse: command accepted
//     mN_rdata / mN_rvalid        read data return to requester N
//     sd_wr_enable/sd_rd_enable   command strobes to the controller
//     sd_addr / sd_wr_data        latched command address / write data
//     sd_rd_data / sd_rd_ready    controller read data and its valid pulse
//     sd_busy                     controller busy
//     err                         watchdog pulse
//
//   Optional feature: define ARB_WATCHDOG_EN to abort a command that the
//   controller never accepts (sd_busy low for 15 cycles in ISSUE). Without
//   it ISSUE waits indefinitely and err stays 0.
// ---------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_wr,
  input  logic                  m0_rd,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_wr,
  input  logic                  m1_rd,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  sd_wr_enable,
  output logic                  sd_rd_enable,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  input  logic                  sd_rd_ready,
  input  logic                  sd_busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic                  grant_r, grant_s;          // owner of the current command
  logic                  op_wr_r, op_wr_s;          // 1: write, 0: read
  logic                  last_grant_r, last_grant_s;
  logic                  rd_done_r, rd_done_s;      // read data already returned
  logic                  wr_en_s, rd_en_s;
  logic                  ack0_s, ack1_s;
  logic                  rv0_s, rv1_s;
  logic                  err_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] rdata0_s, rdata1_s;
  logic                  req0_s, req1_s, pick_s;

`ifdef ARB_WATCHDOG_EN
  logic [3:0] wd_cnt_r, wd_cnt_s;
`endif

  assign req0_s = m0_wr | m0_rd;
  assign req1_s = m1_wr | m1_rd;

  // Round-robin winner: the other requester when both ask, else the only one.
  always_comb begin
    if (req0_s && req1_s) begin
      pick_s = ~last_grant_r;
    end else begin
      pick_s = req1_s;
    end
  end

  // Next-state and next-output logic; every output below is registered.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    op_wr_s      = op_wr_r;
    last_grant_s = last_grant_r;
    rd_done_s    = rd_done_r;
    addr_s       = sd_addr;
    wdata_s      = sd_wr_data;
    rdata0_s     = m0_rdata;
    rdata1_s     = m1_rdata;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    rv0_s        = 1'b0;
    rv1_s        = 1'b0;
    err_s        = 1'b0;
`ifdef ARB_WATCHDOG_EN
    wd_cnt_s     = wd_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req0_s || req1_s) begin
          grant_s   = pick_s;
          // Write wins over a simultaneous read; the read stays pending.
          op_wr_s   = pick_s ? m1_wr : m0_wr;
          addr_s    = pick_s ? m1_addr : m0_addr;
          wdata_s   = pick_s ? m1_wdata : m0_wdata;
          wr_en_s   = op_wr_s;
          rd_en_s   = ~op_wr_s;
          rd_done_s = 1'b0;
          state_s   = ISSUE;
`ifdef ARB_WATCHDOG_EN
          wd_cnt_s  = 4'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (sd_busy) begin
          // Controller took the command: drop the strobe, acknowledge owner.
          ack0_s       = ~grant_r;
          ack1_s       = grant_r;
          last_grant_s = grant_r;
          state_s      = BUSY;
          if (sd_rd_ready && !op_wr_r) begin
            rd_done_s = 1'b1;
            if (grant_r) begin
              rdata1_s = sd_rd_data;
              rv1_s    = 1'b1;
            end else begin
              rdata0_s = sd_rd_data;
              rv0_s    = 1'b1;
            end
          end else begin
            rd_done_s = rd_done_r;
          end
        end else begin
          wr_en_s = op_wr_r;
          rd_en_s = ~op_wr_r;
`ifdef ARB_WATCHDOG_EN
          // 15th consecutive idle cycle: abort without ack, pointer untouched.
          if (wd_cnt_r == 4'd14) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
            err_s   = 1'b1;
            state_s = IDLE;
          end else begin
            wd_cnt_s = wd_cnt_r + 4'd1;
          end
`endif
        end
      end
      BUSY: begin
        if (sd_rd_ready && !op_wr_r) begin
          rd_done_s = 1'b1;
          if (grant_r) begin
            rdata1_s = sd_rd_data;
            rv1_s    = 1'b1;
          end else begin
            rdata0_s = sd_rd_data;
            rv0_s    = 1'b1;
          end
        end else begin
          rd_done_s = rd_done_r;
        end
        if (!sd_busy && (op_wr_r || rd_done_s)) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= 1'b0;
      op_wr_r      <= 1'b0;
      last_grant_r <= 1'b1;  // m0 wins the first contention after reset
      rd_done_r    <= 1'b0;
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      sd_addr      <= {ADDR_WIDTH{1'b0}};
      sd_wr_data   <= {DATA_WIDTH{1'b0}};
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= {DATA_WIDTH{1'b0}};
      m1_rdata     <= {DATA_WIDTH{1'b0}};
      err          <= 1'b0;
    end else begin
      grant_r      <= grant_s;
      op_wr_r      <= op_wr_s;
      last_grant_r <= last_grant_s;
      rd_done_r    <= rd_done_s;
      sd_wr_enable <= wr_en_s;
      sd_rd_enable <= rd_en_s;
      sd_addr      <= addr_s;
      sd_wr_data   <= wdata_s;
      m0_ack       <= ack0_s;
      m1_ack       <= ack1_s;
      m0_rvalid    <= rv0_s;
      m1_rvalid    <= rv1_s;
      m0_rdata     <= rdata0_s;
      m1_rdata     <= rdata1_s;
      err          <= err_s;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Watchdog cycle counter for the ISSUE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= 4'd0;
    end else begin
      wd_cnt_r <= wd_cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter: a cycle-by-cycle vector table for a
//   single write and a read return, then hand-written sequences for
//   contention, write+read from one requester, reset mid-command and the
//   ISSUE wait / watchdog behaviour (selected by ARB_WATCHDOG_EN).
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_wr, m0_rd, m1_wr, m1_rd;
  logic [23:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        sd_wr_enable, sd_rd_enable;
  logic [23:0] sd_addr;
  logic [15:0] sd_wr_data;
  logic [15:0] sd_rd_data;
  logic        sd_rd_ready, sd_busy;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .sd_wr_enable(sd_wr_enable), .sd_rd_enable(sd_rd_enable),
    .sd_addr(sd_addr), .sd_wr_data(sd_wr_data),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
    .err(err)
  );

  // {wr_en, rd_en, ack0, ack1, rv0, rv1, err, rdata0, rdata1, addr, wdata}
  typedef struct packed {
    logic        rst, m0_wr, m0_rd, m1_wr, m1_rd, busy, rdy;
    logic [15:0] rdat;
    logic [78:0] exp;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [78:0] ex(input logic wr, rd, a0, a1, v0, v1, e,
                                     input logic [15:0] r0, r1,
                                     input logic [23:0] ad,
                                     input logic [15:0] wd);
    return {wr, rd, a0, a1, v0, v1, e, r0, r1, ad, wd};
  endfunction

  function automatic vec_t mk(input logic r, a, b, c, d, bz, rdy,
                              input logic [15:0] rdat, input logic [78:0] e);
    vec_t v;
    v.rst = r; v.m0_wr = a; v.m0_rd = b; v.m1_wr = c; v.m1_rd = d;
    v.busy = bz; v.rdy = rdy; v.rdat = rdat; v.exp = e;
    return v;
  endfunction

  function automatic logic [78:0] outs();
    return {sd_wr_enable, sd_rd_enable, m0_ack, m1_ack, m0_rvalid, m1_rvalid,
            err, m0_rdata, m1_rdata, sd_addr, sd_wr_data};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
    sd_busy = 1'b0; sd_rd_ready = 1'b0; sd_rd_data = 16'h0000;
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a strobe, accept it, return read data, finish it.
  task automatic do_cmd(input logic [15:0] rdat, input bit drop,
                        output int who, output bit was_wr);
    int n = 0;
    who = -1;
    was_wr = 1'b0;
    while (!(sd_wr_enable || sd_rd_enable) && n < 20) begin
      tick();
      n++;
    end
    chk("enable_seen", {79'd0, sd_wr_enable | sd_rd_enable}, 80'd1);
    if (!(sd_wr_enable || sd_rd_enable)) return;
    was_wr = sd_wr_enable;
    sd_busy = 1'b1;
    tick();
    who = m0_ack ? 0 : (m1_ack ? 1 : -1);
    chk("ack_enables_low", {78'd0, sd_wr_enable, sd_rd_enable}, 80'd0);
    if (drop) begin
      if (who == 0) begin
        if (was_wr) m0_wr = 1'b0; else m0_rd = 1'b0;
      end else if (who == 1) begin
        if (was_wr) m1_wr = 1'b0; else m1_rd = 1'b0;
      end
    end
    if (!was_wr) begin
      sd_rd_ready = 1'b1;
      sd_rd_data = rdat;
      tick();
      sd_rd_ready = 1'b0;
      chk("rvalid_rdata",
          {62'd0, m0_rvalid, m1_rvalid, (who == 1) ? m1_rdata : m0_rdata},
          {62'd0, (who == 0), (who == 1), rdat});
    end
    tick();
    sd_busy = 1'b0;
    tick();
  endtask

  initial begin
    int who;
    bit was_wr;
    int n;
    bit ok;

    m0_addr = 24'h000010; m0_wdata = 16'hBEEF;
    m1_addr = 24'h000020; m1_wdata = 16'h5555;
    rst = 1'b1;
    m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
    sd_busy = 1'b0; sd_rd_ready = 1'b0; sd_rd_data = 16'h0000;

    //               rst  m0w  m0r  m1w  m1r  busy rdy  rdat
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000000,16'h0000));
    tbl[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000000,16'h0000));
    tbl[2]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[3]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[4]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000010,16'hBEEF));
    tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, ex(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000020,16'h5555));
    tbl[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000020,16'h5555));
    tbl[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,24'h000020,16'h5555));
    tbl[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'h1234, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h1234,24'h000020,16'h5555));
    tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h1234,24'h000020,16'h5555));
    tbl[15] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'hAAAA, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h1234,24'h000020,16'h5555));
    tbl[16] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, ex(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h1234,24'h000020,16'h5555));

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst;
      m0_wr = tbl[i].m0_wr; m0_rd = tbl[i].m0_rd;
      m1_wr = tbl[i].m1_wr; m1_rd = tbl[i].m1_rd;
      sd_busy = tbl[i].busy; sd_rd_ready = tbl[i].rdy; sd_rd_data = tbl[i].rdat;
      tick();
      chk($sformatf("vec%0d", i), {1'b0, outs()}, {1'b0, tbl[i].exp});
    end

    // Continuous contention: grants alternate starting with m0.
    rst_pulse();
    m0_wr = 1'b1; m1_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_cmd(16'h0000, 1'b0, who, was_wr);
      chk($sformatf("contention_grant%0d", k), {48'd0, who}, {48'd0, 32'(k % 2)});
    end
    m0_wr = 1'b0; m1_wr = 1'b0;

    // Same requester write+read: write first, read on the next grant.
    rst_pulse();
    m0_wr = 1'b1; m0_rd = 1'b1;
    do_cmd(16'h0000, 1'b1, who, was_wr);
    chk("wrrd_first", {47'd0, was_wr, who}, {47'd0, 1'b1, 32'd0});
    do_cmd(16'hC0DE, 1'b1, who, was_wr);
    chk("wrrd_second", {47'd0, was_wr, who}, {47'd0, 1'b0, 32'd0});
    chk("wrrd_released", {78'd0, m0_wr, m0_rd}, 80'd0);

    // Reset while a read is in BUSY: everything clears, late data ignored.
    rst_pulse();
    m1_rd = 1'b1;
    n = 0;
    while (!sd_rd_enable && n < 20) begin
      tick();
      n++;
    end
    chk("rstmid_enable", {79'd0, sd_rd_enable}, 80'd1);
    sd_busy = 1'b1;
    tick();
    m1_rd = 1'b0;
    chk("rstmid_ack", {79'd0, m1_ack}, 80'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_cleared", {1'b0, outs()}, 80'd0);
    sd_rd_ready = 1'b1; sd_rd_data = 16'h7777;
    tick();
    sd_rd_ready = 1'b0; sd_busy = 1'b0;
    chk("rstmid_no_rvalid", {1'b0, outs()}, 80'd0);

    // Controller never goes busy.
    rst_pulse();
    m0_rd = 1'b1;
    tick();  // request sampled: strobe now high
    chk("issue_enable", {79'd0, sd_rd_enable}, 80'd1);
`ifdef ARB_WATCHDOG_EN
    ok = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i < 15) begin
        if (!(sd_rd_enable && !err && !m0_ack)) ok = 1'b0;
      end else begin
        chk("watchdog_fire", {77'd0, sd_rd_enable, err, m0_ack}, {77'd0, 1'b0, 1'b1, 1'b0});
      end
    end
    chk("watchdog_wait", {79'd0, ok}, 80'd1);
    tick();
    chk("watchdog_err_pulse", {79'd0, err}, 80'd0);
`else
    ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!(sd_rd_enable && !err && !m0_ack)) ok = 1'b0;
    end
    chk("issue_held", {79'd0, ok}, 80'd1);
`endif
    m0_rd = 1'b0;
    rst_pulse();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
